alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Parametrised, handshaked successor to the team's 40-bit single-cycle ALU.
- Keeps the same opcode encoding. Add and sub complete in one cycle.
- Multiply and divide run as iterative shift-add and restoring-division units, so wide operands close timing.
- Sits between the operand-fetch stage and the writeback register. It accepts one operation at a time.

Parameters:
- WIDTH, 40, operand/result width in bits (minimum 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- s  input  5  opcode: 00101 add, 00110 sub, 01000 mul, 01011 div.
- out_valid  output  1  one-cycle pulse: out/rem/err are valid.
- out  output  WIDTH  result.
- rem  output  WIDTH  division remainder; 0 for other ops.
- err  output  1  divide-by-zero or illegal opcode; qualified by out_valid.

Behaviour:
- Reset: asynchronous, active-high. Asserting rst immediately forces:
  - state=IDLE, in_ready=1, out_valid=0, out=0, rem=0, err=0, counter=0.
  - Any in-flight mul/div is abandoned; no out_valid is ever produced for it.
- Accept: an operation is accepted at a rising edge where in_valid && in_ready. a, b and s are captured at that edge; later input changes have no effect.
- FSM states: IDLE, MUL, DIV.
  - IDLE: in_ready=1.
  - Accept add/sub/illegal: stay in IDLE.
  - Accept mul: go to MUL. Accept div: go to DIV. Counter cleared on either.
  - MUL/DIV: in_ready=0. One iteration per edge. Return to IDLE on the WIDTH-th iteration edge.
- Add/sub latency: out, rem=0, err=0 and out_valid=1 are registered at the accept edge, so visible the cycle after accept.
  - add: out = (a+b) mod 2^WIDTH.
  - sub: out = (a-b) mod 2^WIDTH (two's-complement wrap).
- Mul latency: accept at edge k; iterations at edges k+1..k+WIDTH; result and out_valid registered at edge k+WIDTH.
  - out = low WIDTH bits of a*b. rem=0, err=0.
- Div latency: same as mul, restoring algorithm, one quotient bit per edge, MSB first.
  - out = a/b, rem = a%b, err=0.
- Divide-by-zero (b==0, div):
  - Accepted and run for the full WIDTH cycles; latency unchanged.
  - out = all ones, rem = a, err=1.
- Illegal opcode: treated like add/sub timing. out=0, rem=0, err=1, out_valid pulse at the accept edge.
- out_valid:
  - High for exactly one cycle per accepted operation.
  - out/rem/err hold their values until the next result is registered.
- Back-to-back operation: in_ready is high in the same cycle out_valid is high, so a new operation may be accepted then.
  - Consecutive add/sub at one per cycle gives out_valid high on consecutive cycles.
- in_valid while busy is ignored; the requester must hold it until in_ready.

Optional Feature:
- Macro: ALU_ITER_FLAGS_EN.
- Defined: adds output port flags[1:0], registered alongside out and reset to 0.
  - flags[0] = zero: out==0.
  - flags[1] = carry/borrow/overflow:
    - add: carry out of bit WIDTH-1.
    - sub: borrow (a<b).
    - mul: any nonzero bit of the product above WIDTH-1.
    - div: 0.
- Not defined: flags port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=40, a=0x0B, b=0x03, s=00101 then 00110 back-to-back → out_valid on two consecutive cycles; out=0x0E then 0x08; err=0.
- WIDTH=40, a=0x0B, b=0x03, s=01000 → in_ready low for 40 cycles; out_valid exactly 40 edges after accept; out=0x21, rem=0.
- WIDTH=40, a=0x0B, b=0x03, s=01011 → out=0x03, rem=0x02, err=0 after 40 cycles. Then b=0 → out=0xFFFFFFFFFF, rem=0x0B, err=1.
- WIDTH=8, a=0x03, b=0x0B, sub → out=0xF8. a=0xFF, b=0x02, mul → out=0xFE. With ALU_ITER_FLAGS_EN: flags=2'b10 for both.
- Start div, assert rst at iteration 10, release → outputs 0, in_ready=1, no out_valid. Next add (a=1, b=1) → out=2.
- s=11111 → one-cycle out_valid with err=1, out=0. in_valid held during a mul → no second accept until in_ready returns.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: handshaked unsigned ALU. Add/sub/illegal finish in the accept
// cycle; multiply (shift-add) and divide (restoring) take WIDTH iterations.
// Optional macro ALU_ITER_FLAGS_EN adds the registered flags[1:0] output
// (bit 0 = result zero, bit 1 = carry/borrow/overflow).
module alu_iter #(
  parameter  int WIDTH = 40,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       s,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             err
`ifdef ALU_ITER_FLAGS_EN
  ,
  output logic [1:0]       flags
`endif
);

  localparam logic [4:0] OP_ADD = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b01011;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e             state, state_next;
  logic               accept;
  logic               last_iter;
  logic [CNT_W-1:0]   cnt;
  // Multiplicand (mul) or divisor (div), captured at accept.
  logic [WIDTH-1:0]   opnd;
  // Mul: {partial product high, multiplier/low product}.
  // Div: {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] iter_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   add_res;
  logic               res_valid;
  logic [WIDTH-1:0]   res_out;
  logic [WIDTH-1:0]   res_rem;
  logic               res_err;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is written with <= so every register samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: iterative ops leave IDLE, return on the last iteration.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && s == OP_MUL)      state_next = MUL;
        else if (accept && s == OP_DIV) state_next = DIV;
      end
      MUL, DIV: begin
        if (last_iter) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One iteration step of shift-add multiply and restoring divide.
  always_comb begin
    mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd} : '0);
    div_shift = p[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift - {1'b0, opnd};
    if (state == MUL)
      iter_next = {mul_sum, p[WIDTH-1:1]};
    else
      iter_next = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   p[WIDTH-2:0], div_ge};
  end

`ifdef ALU_ITER_FLAGS_EN
  logic add_carry;
  logic res_ovf;

  assign {add_carry, add_res} = {1'b0, a} + {1'b0, b};

  // Carry/borrow/overflow for whichever result is being registered.
  always_comb begin
    res_ovf = 1'b0;
    if (state == IDLE) begin
      case (s)
        OP_ADD:  res_ovf = add_carry;
        OP_SUB:  res_ovf = (a < b);
        default: res_ovf = 1'b0;
      endcase
    end else if (state == MUL) begin
      res_ovf = |iter_next[2*WIDTH-1:WIDTH];
    end
  end

  // Flags register, updated together with out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            flags <= 2'b00;
    else if (res_valid) flags <= {res_ovf, (res_out == '0)};
  end
`else
  assign add_res = a + b;
`endif

  // Result selection: single-cycle ops at accept, iterative ops at the end.
  always_comb begin
    res_valid = 1'b0;
    res_out   = '0;
    res_rem   = '0;
    res_err   = 1'b0;
    if (state == IDLE) begin
      if (accept) begin
        case (s)
          OP_ADD: begin
            res_valid = 1'b1;
            res_out   = add_res;
          end
          OP_SUB: begin
            res_valid = 1'b1;
            res_out   = a - b;
          end
          OP_MUL, OP_DIV: res_valid = 1'b0;
          default: begin
            res_valid = 1'b1;
            res_err   = 1'b1;
          end
        endcase
      end
    end else if (last_iter) begin
      res_valid = 1'b1;
      res_out   = iter_next[WIDTH-1:0];
      if (state == DIV) begin
        // A zero divisor naturally yields all-ones quotient and rem = a.
        res_rem = iter_next[2*WIDTH-1:WIDTH];
        res_err = (opnd == '0);
      end
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the iteration registers are reset too; they are few and a clean
    // state after reset keeps an abandoned operation from leaking anywhere.
    if (rst) begin
      cnt       <= '0;
      opnd      <= '0;
      p         <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      rem       <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= res_valid;
      if (res_valid) begin
        out <= res_out;
        rem <= res_rem;
        err <= res_err;
      end
      if (accept) begin
        cnt  <= '0;
        opnd <= (s == OP_MUL) ? a : b;
        p    <= (s == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      end else if (state == MUL || state == DIV) begin
        cnt <= cnt + CNT_W'(1);
        p   <= iter_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: WIDTH=40 instance driven through a
// scoreboard (table vectors, random ops, hand-written timing sequences) and
// a WIDTH=8 instance for the narrow wrap/overflow cases.
// Flag checks are compiled in when ALU_ITER_FLAGS_EN is defined.
module tb_alu_iter;

  localparam int W  = 40;
  localparam int W8 = 8;

  localparam logic [4:0] OP_ADD = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b01011;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] rem;
    logic         err;
    logic [1:0]   flags;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   s;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [4:0]   s;
  logic         out_valid;
  logic [W-1:0] out, rem;
  logic         err;
  logic [1:0]   flags;

  logic          iv8, ir8, ov8, e8;
  logic [W8-1:0] a8, b8, o8, r8;
  logic [4:0]    s8;
  logic [1:0]    f8;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .out_valid(out_valid), .out(out), .rem(rem),
    .err(err)
`ifdef ALU_ITER_FLAGS_EN
    , .flags(flags)
`endif
  );

  alu_iter #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .s(s8), .out_valid(ov8), .out(o8), .rem(r8),
    .err(e8)
`ifdef ALU_ITER_FLAGS_EN
    , .flags(f8)
`endif
  );

`ifndef ALU_ITER_FLAGS_EN
  assign flags = 2'b00;
  assign f8    = 2'b00;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic [W-1:0] o, input logic [W-1:0] r,
                                  input logic er, input logic [1:0] f);
    exp_t e;
    e.out = o; e.rem = r; e.err = er; e.flags = f;
    return e;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic [4:0] ts, input logic [W-1:0] o,
                              input logic [W-1:0] r, input logic er, input logic [1:0] f);
    vec_t v;
    v.a = ta; v.b = tb; v.s = ts; v.e = mk_exp(o, r, er, f);
    return v;
  endfunction

  // Reference model built on the simulator's own arithmetic.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic [4:0] ts);
    exp_t         e;
    logic [W:0]   wide;
    logic [2*W-1:0] prod;
    e = mk_exp('0, '0, 1'b0, 2'b00);
    case (ts)
      OP_ADD: begin
        wide = {1'b0, ta} + {1'b0, tb};
        e.out = wide[W-1:0];
        e.flags[1] = wide[W];
      end
      OP_SUB: begin
        e.out = ta - tb;
        e.flags[1] = (ta < tb);
      end
      OP_MUL: begin
        prod = {{W{1'b0}}, ta} * {{W{1'b0}}, tb};
        e.out = prod[W-1:0];
        e.flags[1] = |prod[2*W-1:W];
      end
      OP_DIV: begin
        if (tb == '0) begin
          e.out = '1; e.rem = ta; e.err = 1'b1;
        end else begin
          e.out = ta / tb; e.rem = ta % tb;
        end
      end
      default: e.err = 1'b1;
    endcase
    e.flags[0] = (e.out == '0);
    return e;
  endfunction

  // Wait for in_ready, present one operation, queue its expected result and
  // return just after the accepting edge (in_valid left high).
  task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [4:0] ts, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      in_valid = 1'b0;
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
    end else begin
      a = ta; b = tb; s = ts; in_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("drain_pending", sb.size(), 0);
  endtask

  // Scoreboard monitor: every out_valid pulse must match the oldest entry.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("sb_out", out, e.out);
        check("sb_rem", rem, e.rem);
        check("sb_err", err, e.err);
`ifdef ALU_ITER_FLAGS_EN
        check("sb_flags", flags, e.flags);
`endif
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t tv[13];
    int   lows;
    int   first_ov;
    int   n;
    logic [W-1:0] ra, rb;
    logic [4:0]   rs;

    tv[0]  = mk(40'h0B, 40'h03, OP_ADD, 40'h0E, 40'h0, 1'b0, 2'b00);
    tv[1]  = mk(40'h0B, 40'h03, OP_SUB, 40'h08, 40'h0, 1'b0, 2'b00);
    tv[2]  = mk(40'hFFFFFFFFFF, 40'h01, OP_ADD, 40'h0, 40'h0, 1'b0, 2'b11);
    tv[3]  = mk(40'h0, 40'h01, OP_SUB, 40'hFFFFFFFFFF, 40'h0, 1'b0, 2'b10);
    tv[4]  = mk(40'h0B, 40'h03, OP_MUL, 40'h21, 40'h0, 1'b0, 2'b00);
    tv[5]  = mk(40'hFFFFFFFFFF, 40'h02, OP_MUL, 40'hFFFFFFFFFE, 40'h0, 1'b0, 2'b10);
    tv[6]  = mk(40'h0B, 40'h03, OP_DIV, 40'h03, 40'h02, 1'b0, 2'b00);
    tv[7]  = mk(40'h0B, 40'h00, OP_DIV, 40'hFFFFFFFFFF, 40'h0B, 1'b1, 2'b00);
    tv[8]  = mk(40'h1234567890, 40'h10, OP_DIV, 40'h0123456789, 40'h0, 1'b0, 2'b00);
    tv[9]  = mk(40'h05, 40'h06, 5'b11111, 40'h0, 40'h0, 1'b1, 2'b01);
    tv[10] = mk(40'h05, 40'h07, OP_DIV, 40'h0, 40'h05, 1'b0, 2'b01);
    tv[11] = mk(40'h100000, 40'h100000, OP_MUL, 40'h0, 40'h0, 1'b0, 2'b11);
    tv[12] = mk(40'h09, 40'h09, 5'b01001, 40'h0, 40'h0, 1'b1, 2'b01);

    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; s = '0;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = '0;

    // Reset values while rst is held.
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 40'h0);
    check("rst_rem", rem, 40'h0);
    check("rst_err", err, 1'b0);
`ifdef ALU_ITER_FLAGS_EN
    check("rst_flags", flags, 2'b00);
`endif
    #20;
    @(negedge clk) rst = 1'b0;

    // Back-to-back add then sub: results on consecutive cycles, then held.
    drive_op(40'h0B, 40'h03, OP_ADD, model(40'h0B, 40'h03, OP_ADD));
    #2;
    check("b2b_add_valid", out_valid, 1'b1);
    check("b2b_add_out", out, 40'h0E);
    drive_op(40'h0B, 40'h03, OP_SUB, model(40'h0B, 40'h03, OP_SUB));
    #2;
    check("b2b_sub_valid", out_valid, 1'b1);
    check("b2b_sub_out", out, 40'h08);
    check("b2b_sub_err", err, 1'b0);
    idle();
    @(posedge clk); #2;
    check("b2b_pulse_end", out_valid, 1'b0);
    check("b2b_out_hold", out, 40'h08);

    // Multiply latency: busy for 40 cycles, result 40 edges after accept.
    drive_op(40'h0B, 40'h03, OP_MUL, mk_exp(40'h21, 40'h0, 1'b0, 2'b00));
    #2;
    lows = (in_ready == 1'b0) ? 1 : 0;
    first_ov = (out_valid == 1'b1) ? 0 : -1;
    idle();
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #2;
      if (!in_ready) lows++;
      if (out_valid && first_ov < 0) first_ov = i;
    end
    check("mul_busy_cycles", lows, 40);
    check("mul_latency", first_ov, 40);

    // Table vectors, issued as fast as the block accepts them.
    for (int i = 0; i < 13; i++) drive_op(tv[i].a, tv[i].b, tv[i].s, tv[i].e);
    idle();
    drain();

    // Illegal opcode: single-cycle pulse with err.
    drive_op(40'h77, 40'h11, 5'b11111, mk_exp(40'h0, 40'h0, 1'b1, 2'b01));
    #2;
    check("illegal_valid", out_valid, 1'b1);
    check("illegal_err", err, 1'b1);
    check("illegal_out", out, 40'h0);
    idle();
    @(posedge clk); #2;
    check("illegal_pulse_end", out_valid, 1'b0);

    // Reset in the middle of a divide abandons it.
    drive_op(40'h0B, 40'h03, OP_DIV, mk_exp(40'h03, 40'h02, 1'b0, 2'b00));
    idle();
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_out", out, 40'h0);
    check("midrst_rem", rem, 40'h0);
    check("midrst_err", err, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk) rst = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    check("midrst_ready_after", in_ready, 1'b1);
    drive_op(40'h01, 40'h01, OP_ADD, mk_exp(40'h02, 40'h0, 1'b0, 2'b00));
    idle();
    drain();

    // in_valid held through a multiply: exactly one accept.
    drive_op(40'hFFFFFFFFFF, 40'hFFFFFFFFFF, OP_MUL,
             mk_exp(40'h01, 40'h0, 1'b0, 2'b10));
    #2;
    lows = (in_ready == 1'b0) ? 1 : 0;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #2;
      n++;
      if (!in_ready) lows++;
    end
    check("held_busy_cycles", lows, 40);
    check("held_latency", n, 40);
    idle();
    repeat (50) @(posedge clk);
    #2;
    check("held_queue_empty", sb.size(), 0);

    // Random operations against the model, back to back.
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom(), $urandom()};
      rb = (i % 3 == 0) ? W'($urandom_range(0, 20)) : {$urandom(), $urandom()};
      case (i % 4)
        0: rs = OP_ADD;
        1: rs = OP_MUL;
        2: rs = OP_DIV;
        default: rs = OP_SUB;
      endcase
      drive_op(ra, rb, rs, model(ra, rb, rs));
    end
    idle();
    drain();

    // WIDTH=8 instance: sub wrap with borrow.
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h0B; s8 = OP_SUB; iv8 = 1'b1;
    @(posedge clk); #1 iv8 = 1'b0;
    #1;
    n = 0;
    while (!ov8 && n < 20) begin @(posedge clk); #2; n++; end
    check("w8_sub_valid", ov8, 1'b1);
    check("w8_sub_out", o8, 8'hF8);
`ifdef ALU_ITER_FLAGS_EN
    check("w8_sub_flags", f8, 2'b10);
`endif

    // WIDTH=8 instance: multiply overflow, 8 iterations.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h02; s8 = OP_MUL; iv8 = 1'b1;
    @(posedge clk); #1 iv8 = 1'b0;
    #1;
    n = 0;
    while (!ov8 && n < 20) begin @(posedge clk); #2; n++; end
    check("w8_mul_latency", n, 8);
    check("w8_mul_out", o8, 8'hFE);
    check("w8_mul_rem", r8, 8'h00);
`ifdef ALU_ITER_FLAGS_EN
    check("w8_mul_flags", f8, 2'b10);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
